datapath_controller: RTL and testbench
======================================

Name: datapath_controller

Overview:
- Moore FSM that sequences the register-file/ALU datapath for the simple RISC instruction set (MOV imm, MOV reg, ADD, CMP, AND, MVN).
- Sits between the instruction register/decoder and the datapath. The decoder supplies readnum/writenum/shift/ALUop/sximm fields. This block drives every state-machine-owned datapath control: vsel, loada, loadb, asel, bsel, loadc, loads, write, plus the register-select nsel.
- Handshake to the top level is start pulse s and wait flag w.

Parameters:
- none; widths fixed by the ISA.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- s  input  1  start; sampled only in WAIT
- opcode  input  3  instruction[15:13]
- op  input  2  instruction[12:11]
- w  output  1  1 = idle, ready for s
- nsel  output  3  one-hot register select to decoder mux: 001 Rn, 010 Rd, 100 Rm, 000 none
- vsel  output  2  writeback source: 00 sximm8, 01 C, 10 {8'b0,PC}, 11 mdata
- loada  output  1  load RA
- loadb  output  1  load RB
- asel  output  1  1 = Ain forced to 0
- bsel  output  1  1 = Bin = sximm5
- loadc  output  1  load RC
- loads  output  1  load status register
- write  output  1  register-file write enable
- illegal  output  1  one-cycle pulse on unsupported opcode/op

Behaviour:
- Reset: the async assert of reset_n=0 forces WAIT and clears the latched opcode/op, at any time including mid-instruction; no partial write completes. Output values under reset: w=1; nsel=000; vsel=00; all load/sel/write=0; illegal=0.
- Output decoding: all outputs are decoded from the state register plus the latched opcode/op only. No combinational path from s/opcode/op to outputs.
- Latching: opcode/op are captured into internal registers on the clock where state==WAIT and s==1. Later input changes are ignored until the instruction returns to WAIT.
- Busy behaviour: s is ignored while w=0.
- States and outputs (unlisted outputs 0, nsel 000, vsel 00):
  - WAIT: w=1.
  - DECODE: no datapath activity.
  - WRITE_IMM: nsel=001, vsel=00, write=1.
  - GET_A: nsel=001, loada=1.
  - GET_B: nsel=100, loadb=1.
  - ALU: asel=1 for MOV-reg only, bsel=0; CMP gives loads=1, loadc=0; all others give loadc=1, loads=0.
  - WRITE_REG: nsel=010, vsel=01, write=1.
- Transitions. DECODE branches on the latched fields:
  - 110/10 MOV imm: DECODE -> WRITE_IMM -> WAIT (busy 2 cycles).
  - 110/00 MOV reg: DECODE -> GET_B -> ALU -> WRITE_REG -> WAIT (4).
  - 101/11 MVN: DECODE -> GET_B -> ALU -> WRITE_REG -> WAIT (4).
  - 101/00 ADD and 101/10 AND: DECODE -> GET_A -> GET_B -> ALU -> WRITE_REG -> WAIT (5).
  - 101/01 CMP: DECODE -> GET_A -> GET_B -> ALU -> WAIT (4); no register write.
  - Anything else: illegal=1 during DECODE, then WAIT (1).
- ALU operation: ALUop comes from op via the decoder. MOV reg relies on op=00 (ADD) with asel=1.
- Ready timing: w rises in the cycle after the last active state. s=1 held continuously re-launches on that same WAIT cycle (back-to-back issue allowed).
- Unknown inputs: X/Z on opcode in DECODE is treated as illegal.

Optional Feature:
- Macro: DP_CTRL_PERF_EN.
- Defined: adds output retired (16 bits), reset to 0 by reset_n. It increments by 1 (wrapping 0xFFFF -> 0x0000) on each transition into WAIT from a legal instruction's final state. Illegal instructions are not counted.
- Undefined: no port and no counter logic; all other behaviour identical.

Test Plan:
- Reset mid-op: launch ADD, drop reset_n during GET_B asynchronously (between clock edges) -> outputs immediately return to the reset values (w=1, all controls 0); write never pulses.
- MOV imm: opcode=110, op=10, s=1 for one clock -> cycle+1 DECODE all 0; cycle+2 nsel=001, vsel=00, write=1, w=0; cycle+3 w=1.
- ADD: opcode=101, op=00 -> loada with nsel=001, then loadb with nsel=100, then loadc=1/loads=0, then write=1 with nsel=010, vsel=01; w low exactly 5 cycles. Change opcode to 110 after launch -> sequence unchanged.
- CMP: 101/01 -> ALU cycle loads=1, loadc=0; write never asserted; w back high after 4 busy cycles.
- MOV reg and MVN: 110/00 gives asel=1 in ALU and no loada; 101/11 gives asel=0, no loada; both write Rd with vsel=01.
- Illegal: opcode=111 -> illegal=1 for exactly one cycle (DECODE), no load/write; s=1 held throughout -> next instruction starts the cycle w returns to 1. With DP_CTRL_PERF_EN: retired unchanged by illegal, +1 per legal instruction.

Source files
------------

// File: rtl/datapath_controller_if.sv
// rtl/datapath_controller_if.sv - handshake and datapath-control bundle for datapath_controller (DP_CTRL_PERF_EN adds retired)
interface datapath_controller_if;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       asel;
    logic       bsel;
    logic       loadc;
    logic       loads;
    logic       write;
    logic       illegal;
`ifdef DP_CTRL_PERF_EN
    logic [15:0] retired;
`endif

    // master issues instructions and consumes controls; slave is the controller
    modport master (
        output s, opcode, op,
        input  w, nsel, vsel, loada, loadb, asel, bsel, loadc, loads, write, illegal
`ifdef DP_CTRL_PERF_EN
        , input retired
`endif
    );

    modport slave (
        input  s, opcode, op,
        output w, nsel, vsel, loada, loadb, asel, bsel, loadc, loads, write, illegal
`ifdef DP_CTRL_PERF_EN
        , output retired
`endif
    );
endinterface

// File: rtl/datapath_controller.sv
// rtl/datapath_controller.sv - Moore FSM sequencing the register-file/ALU datapath (DP_CTRL_PERF_EN adds retired counter)
module datapath_controller (
    input  logic                  clk,
    input  logic                  reset_n,
    datapath_controller_if.slave  dp
);

    typedef enum logic [2:0] {
        ST_WAIT      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_WRITE_IMM = 3'd2,
        ST_GET_A     = 3'd3,
        ST_GET_B     = 3'd4,
        ST_ALU       = 3'd5,
        ST_WRITE_REG = 3'd6
    } state_t;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

    localparam logic [1:0] VSEL_IMM  = 2'b00;
    localparam logic [1:0] VSEL_C    = 2'b01;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] opcode_q;
    logic [1:0] op_q;

    logic       is_mov_reg;
    logic       is_cmp;

    // Instruction fields are frozen at launch so the decoder may move on.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_WAIT;
            opcode_q <= 3'b000;
            op_q     <= 2'b00;
        end else begin
            state_q <= state_d;
            if (state_q == ST_WAIT && dp.s) begin
                opcode_q <= dp.opcode;
                op_q     <= dp.op;
            end
        end
    end

    assign is_mov_reg = (opcode_q == 3'b110) && (op_q == 2'b00);
    assign is_cmp     = (opcode_q == 3'b101) && (op_q == 2'b01);

    always_comb begin
        state_d    = state_q;
        dp.w       = 1'b0;
        dp.nsel    = NSEL_NONE;
        dp.vsel    = VSEL_IMM;
        dp.loada   = 1'b0;
        dp.loadb   = 1'b0;
        dp.asel    = 1'b0;
        dp.bsel    = 1'b0;
        dp.loadc   = 1'b0;
        dp.loads   = 1'b0;
        dp.write   = 1'b0;
        dp.illegal = 1'b0;

        case (state_q)
            ST_WAIT: begin
                dp.w = 1'b1;
                if (dp.s) begin
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                // Unknown or unsupported encodings fall to the default arm.
                case ({opcode_q, op_q})
                    5'b110_10: state_d = ST_WRITE_IMM;
                    5'b110_00,
                    5'b101_11: state_d = ST_GET_B;
                    5'b101_00,
                    5'b101_10,
                    5'b101_01: state_d = ST_GET_A;
                    default: begin
                        dp.illegal = 1'b1;
                        state_d    = ST_WAIT;
                    end
                endcase
            end

            ST_WRITE_IMM: begin
                dp.nsel  = NSEL_RN;
                dp.vsel  = VSEL_IMM;
                dp.write = 1'b1;
                state_d  = ST_WAIT;
            end

            ST_GET_A: begin
                dp.nsel  = NSEL_RN;
                dp.loada = 1'b1;
                state_d  = ST_GET_B;
            end

            ST_GET_B: begin
                dp.nsel  = NSEL_RM;
                dp.loadb = 1'b1;
                state_d  = ST_ALU;
            end

            ST_ALU: begin
                // MOV reg runs as ADD with A forced to zero; CMP only updates status.
                dp.asel  = is_mov_reg;
                dp.loads = is_cmp;
                dp.loadc = !is_cmp;
                state_d  = is_cmp ? ST_WAIT : ST_WRITE_REG;
            end

            ST_WRITE_REG: begin
                dp.nsel  = NSEL_RD;
                dp.vsel  = VSEL_C;
                dp.write = 1'b1;
                state_d  = ST_WAIT;
            end

            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

`ifdef DP_CTRL_PERF_EN
    logic [15:0] retired_q;
    logic        retire;

    // Every legal instruction ends in exactly one of these states.
    assign retire = (state_q == ST_WRITE_IMM) ||
                    (state_q == ST_WRITE_REG) ||
                    (state_q == ST_ALU && is_cmp);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retired_q <= 16'h0000;
        end else if (retire) begin
            retired_q <= retired_q + 16'h0001;
        end
    end

    assign dp.retired = retired_q;
`endif

endmodule

// File: tb/tb_datapath_controller.sv
// tb/tb_datapath_controller.sv - scoreboard bench for datapath_controller
module tb_datapath_controller;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    datapath_controller_if dp();

    datapath_controller u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .dp      (dp)
    );

    int total = 0;
    int bad = 0;
    logic [13:0] exp_q[$];
    bit sb_on = 1'b0;
    int legal_cnt = 0;

    // {w, nsel, vsel, loada, loadb, asel, bsel, loadc, loads, write, illegal}
    function automatic logic [13:0] mk(input logic w, input logic [2:0] nsel, input logic [1:0] vsel,
                                       input logic la, input logic lb, input logic as, input logic bs,
                                       input logic lc, input logic ls, input logic wr, input logic il);
        return {w, nsel, vsel, la, lb, as, bs, lc, ls, wr, il};
    endfunction

    function automatic logic [13:0] obs();
        return {dp.w, dp.nsel, dp.vsel, dp.loada, dp.loadb, dp.asel, dp.bsel,
                dp.loadc, dp.loads, dp.write, dp.illegal};
    endfunction

    logic [13:0] idle_w;
    initial idle_w = mk(1'b1, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected control word for every cycle from launch to last busy cycle.
    task automatic model_push(input logic [2:0] opc, input logic [1:0] opv, output int n);
        bit mov_imm, mov_reg, mvn, add_and, cmp, legal;
        mov_imm = (opc == 3'd6) && (opv == 2'd2);
        mov_reg = (opc == 3'd6) && (opv == 2'd0);
        mvn     = (opc == 3'd5) && (opv == 2'd3);
        add_and = (opc == 3'd5) && (opv == 2'd0 || opv == 2'd2);
        cmp     = (opc == 3'd5) && (opv == 2'd1);
        legal   = mov_imm || mov_reg || mvn || add_and || cmp;
        if (legal) legal_cnt++;
        exp_q.push_back(idle_w);
        exp_q.push_back(mk(1'b0, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, !legal));
        n = 1;
        if (mov_imm) begin
            exp_q.push_back(mk(1'b0, 3'b001, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
            n++;
        end else if (legal) begin
            if (add_and || cmp) begin
                exp_q.push_back(mk(1'b0, 3'b001, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
                n++;
            end
            exp_q.push_back(mk(1'b0, 3'b100, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            exp_q.push_back(mk(1'b0, 3'b000, 2'b00, 1'b0, 1'b0, mov_reg, 1'b0, !cmp, cmp, 1'b0, 1'b0));
            n += 2;
            if (!cmp) begin
                exp_q.push_back(mk(1'b0, 3'b010, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
                n++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (sb_on) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL seq_underflow actual=%h required=queued_entry at %0t", obs(), $time);
            end else begin
                check("seq", {2'b00, obs()}, {2'b00, exp_q.pop_front()});
            end
        end
    end

    logic [4:0] directed [0:7];
    initial begin
        directed[0] = 5'b110_10;
        directed[1] = 5'b101_00;
        directed[2] = 5'b101_01;
        directed[3] = 5'b110_00;
        directed[4] = 5'b101_11;
        directed[5] = 5'b101_10;
        directed[6] = 5'b111_00;
        directed[7] = 5'b111_11;
    end

    initial begin
        int n;
        int gap;
        logic [4:0] ins;
        dp.s = 1'b0;
        dp.opcode = 3'b000;
        dp.op = 2'b00;

        #2;
        check("reset_outputs", {2'b00, obs()}, {2'b00, idle_w});
`ifdef DP_CTRL_PERF_EN
        check("reset_retired", dp.retired, 16'h0000);
`endif
        @(negedge clk);
        reset_n = 1'b1;

        // Asynchronous reset in the middle of an ADD
        @(posedge clk); #1;
        dp.s = 1'b1; dp.opcode = 3'b101; dp.op = 2'b00;
        @(posedge clk); #1;
        dp.s = 1'b0;
        check("add_decode", {2'b00, obs()}, 16'h0000);
        @(posedge clk); #1;
        check("add_get_a", {2'b00, obs()},
              {2'b00, mk(1'b0, 3'b001, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
        @(posedge clk); #3;
        check("add_get_b", {2'b00, obs()},
              {2'b00, mk(1'b0, 3'b100, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
        reset_n = 1'b0;
        #1;
        check("async_reset_mid_op", {2'b00, obs()}, {2'b00, idle_w});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_no_write", {15'd0, dp.write}, 16'h0000);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("after_reset_idle", {2'b00, obs()}, {2'b00, idle_w});
        @(posedge clk); #1;
        check("after_reset_no_resume", {2'b00, obs()}, {2'b00, idle_w});
`ifdef DP_CTRL_PERF_EN
        check("retired_after_abort", dp.retired, 16'h0000);
`endif

        // Scoreboarded stream: directed set first, then random
        sb_on = 1'b1;
        for (int k = 0; k < 308; k++) begin
            if (k < 8) begin
                ins = directed[k];
            end else if ($urandom_range(0, 9) < 7) begin
                ins = directed[$urandom_range(0, 5)];
            end else begin
                ins = 5'($urandom);
            end
            dp.s = 1'b1;
            dp.opcode = ins[4:2];
            dp.op = ins[1:0];
            model_push(ins[4:2], ins[1:0], n);
            @(posedge clk); #1;
            dp.opcode = 3'($urandom);
            dp.op = 2'($urandom);
            dp.s = 1'($urandom);
            repeat (n - 1) begin
                @(posedge clk); #1;
            end
            @(posedge clk); #1;
            gap = (k == 6) ? 0 : $urandom_range(0, 2);
            repeat (gap) begin
                dp.s = 1'b0;
                exp_q.push_back(idle_w);
                @(posedge clk); #1;
            end
        end
        dp.s = 1'b0;
        exp_q.push_back(idle_w);
        @(negedge clk); #1;
        sb_on = 1'b0;
        check("queue_drained", 16'(exp_q.size()), 16'h0000);
`ifdef DP_CTRL_PERF_EN
        check("retired_count", dp.retired, 16'(legal_cnt));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
